// File: rtl/dyser_pkg.sv
// dyser_pkg: shared DySER widths and types.
// No ports. Provides DATA_WIDTH (data MSB index), NPORTS, PORT_W,
// the port-id type and the data-word type (also used by the egress block).
package dyser_pkg;
  localparam int DATA_WIDTH = 63;
  localparam int NPORTS = 8;
  localparam int PORT_W = 3;
  typedef logic [PORT_W-1:0] port_id_t;
  typedef logic [DATA_WIDTH:0] word_t;
endpackage

// File: rtl/dyser_send_ingress_if.sv
// dyser_send_ingress_if: core send lanes and fabric-side port handshake.
// Core side: send_data_r0/r1, send_port_r0/r1, send_en0/1, config_en in; send_stall out.
// Fabric side: port_valid/port_data out; port_ready in.
// slave = ingress block, master = driver of sends and consumer of ports.
interface dyser_send_ingress_if;
  import dyser_pkg::*;
  word_t send_data_r0, send_data_r1;
  port_id_t send_port_r0, send_port_r1;
  logic send_en0, send_en1, config_en, send_stall;
  logic [NPORTS-1:0] port_valid, port_ready;
  logic [NPORTS*(DATA_WIDTH+1)-1:0] port_data;
  modport slave (
    input send_data_r0, send_data_r1, send_port_r0, send_port_r1,
    input send_en0, send_en1, config_en, port_ready,
    output send_stall, port_valid, port_data
  );
  modport master (
    output send_data_r0, send_data_r1, send_port_r0, send_port_r1,
    output send_en0, send_en1, config_en, port_ready,
    input send_stall, port_valid, port_data
  );
endinterface

// File: rtl/dyser_port_fifo.sv
// dyser_port_fifo: per-port FIFO taking up to two pushes (lane 0 first) and one pop per cycle.
// Ports: clk, rst (async), push0/din0, push1/din1, pop, flush (sync clear of count/pointers);
// count (occupancy), head (storage entry at rd pointer, unregistered), valid (count != 0).
module dyser_port_fifo
  import dyser_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  logic          push1,
  input  word_t         din0,
  input  word_t         din1,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output word_t         head,
  output logic          valid
);
  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push0) mem_d[wr_ptr_q] = din0;
    // lane 1 lands behind lane 0 when both push in the same cycle
    if (push1) mem_d[push0 ? wr_ptr_q + PW'(1) : wr_ptr_q] = din1;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head = mem_q[rd_ptr_q];
  assign valid = count_q != '0;
endmodule

// File: rtl/dyser_send_ingress.sv
// dyser_send_ingress: steers dual-lane dyser_send words into per-port FIFOs for the fabric.
// Ports: clk, rst (async, active-high), io (slave modport of dyser_send_ingress_if).
// A send is accepted atomically: either every enabled lane is written or none (send_stall).
module dyser_send_ingress
  import dyser_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  dyser_send_ingress_if.slave io
);
  logic [NPORTS-1:0] over, push0, push1, pop, valid;
  logic [CW-1:0] count [NPORTS];
  word_t head [NPORTS];
  logic stall;
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic hit0, hit1;
    assign hit0 = io.send_en0 && io.send_port_r0 == PORT_W'(p);
    assign hit1 = io.send_en1 && io.send_port_r1 == PORT_W'(p);
    // free space uses registered count only; a same-cycle pop is not credited
    assign over[p] = CW'(hit0) + CW'(hit1) > CW'(DEPTH) - count[p];
    assign push0[p] = hit0 && !stall;
    assign push1[p] = hit1 && !stall;
    assign pop[p] = valid[p] && io.port_ready[p];
    dyser_port_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push0(push0[p]), .push1(push1[p]),
      .din0(io.send_data_r0), .din1(io.send_data_r1),
      .pop(pop[p]), .flush(io.config_en),
      .count(count[p]), .head(head[p]), .valid(valid[p])
    );
    assign io.port_data[p*(DATA_WIDTH+1) +: DATA_WIDTH+1] = head[p];
  end
  assign stall = !rst && (|over || io.config_en);
  assign io.send_stall = stall;
  assign io.port_valid = valid;
endmodule

// File: tb/tb_dyser_send_ingress.sv
// tb_dyser_send_ingress: directed self-checking bench for dyser_send_ingress.
module tb_dyser_send_ingress;
  import dyser_pkg::*;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  dyser_send_ingress_if io ();
  dyser_send_ingress #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .io(io.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic word_t pd(input int p);
    return io.port_data[p*64 +: 64];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic e0, input port_id_t p0, input word_t d0,
                      input logic e1, input port_id_t p1, input word_t d1);
    io.send_en0 = e0; io.send_port_r0 = p0; io.send_data_r0 = d0;
    io.send_en1 = e1; io.send_port_r1 = p1; io.send_data_r1 = d1;
    #1;
  endtask
  task automatic idle;
    send(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1;
    io.config_en = 1;
    io.port_ready = '0;
    send(1, 4, 64'h9, 0, 0, 0);
    chk("rst_valid", 64'(io.port_valid), 64'h0);
    chk("rst_data", 64'(io.port_data[63:0]), 64'h0);
    chk("rst_stall", 64'(io.send_stall), 64'h0);
    tick;
    io.config_en = 0;
    idle;
    rst = 0;
    tick;
    send(1, 4, 64'h0, 1, 3, 64'h1);
    chk("t1_stall", 64'(io.send_stall), 64'h0);
    tick;
    idle;
    chk("t1_valid", 64'(io.port_valid), 64'h18);
    chk("t1_d4", pd(4), 64'h0);
    chk("t1_d3", pd(3), 64'h1);
    io.port_ready = 8'h18;
    tick;
    io.port_ready = '0;
    chk("t1_drained", 64'(io.port_valid), 64'h0);
    send(1, 2, 64'h55, 1, 2, 64'hff);
    tick;
    idle;
    chk("t2_valid", 64'(io.port_valid), 64'h04);
    chk("t2_head0", pd(2), 64'h55);
    io.port_ready = 8'h04;
    tick;
    chk("t2_head1", pd(2), 64'hff);
    chk("t2_valid1", 64'(io.port_valid), 64'h04);
    tick;
    io.port_ready = '0;
    chk("t2_empty", 64'(io.port_valid), 64'h0);
    send(1, 6, 64'ha0, 1, 6, 64'ha1);
    tick;
    send(1, 6, 64'ha2, 1, 6, 64'ha3);
    tick;
    send(1, 6, 64'ha4, 0, 0, 0);
    chk("t3_full_stall", 64'(io.send_stall), 64'h1);
    tick;
    chk("t3_no_write", pd(6), 64'ha0);
    io.port_ready = 8'h40;
    #1;
    chk("t3_pop_not_credited", 64'(io.send_stall), 64'h1);
    tick;
    io.port_ready = '0;
    #1;
    chk("t3_stall_clear", 64'(io.send_stall), 64'h0);
    tick;
    idle;
    io.port_ready = 8'h40;
    #1;
    chk("t3_q1", pd(6), 64'ha1);
    tick;
    chk("t3_q2", pd(6), 64'ha2);
    tick;
    chk("t3_q3", pd(6), 64'ha3);
    tick;
    chk("t3_q4", pd(6), 64'ha4);
    tick;
    io.port_ready = '0;
    chk("t3_empty", 64'(io.port_valid), 64'h0);
    send(1, 0, 64'hb0, 1, 0, 64'hb1);
    tick;
    send(1, 0, 64'hb2, 0, 0, 0);
    tick;
    send(1, 0, 64'hc0, 1, 0, 64'hc1);
    chk("t4_atomic_stall", 64'(io.send_stall), 64'h1);
    tick;
    chk("t4_head", pd(0), 64'hb0);
    io.port_ready = 8'h01;
    tick;
    io.port_ready = '0;
    #1;
    chk("t4_stall_clear", 64'(io.send_stall), 64'h0);
    tick;
    idle;
    io.port_ready = 8'h01;
    #1;
    chk("t4_q1", pd(0), 64'hb1);
    tick;
    chk("t4_q2", pd(0), 64'hb2);
    tick;
    chk("t4_q3", pd(0), 64'hc0);
    tick;
    chk("t4_q4", pd(0), 64'hc1);
    tick;
    io.port_ready = '0;
    chk("t4_empty", 64'(io.port_valid), 64'h0);
    send(1, 1, 64'hd0, 1, 5, 64'hd1);
    tick;
    chk("t5_valid", 64'(io.port_valid), 64'h22);
    send(1, 7, 64'hd2, 0, 0, 0);
    io.config_en = 1;
    #1;
    chk("t5_cfg_stall", 64'(io.send_stall), 64'h1);
    tick;
    io.config_en = 0;
    idle;
    chk("t5_flushed", 64'(io.port_valid), 64'h0);
    chk("t5_idle_stall", 64'(io.send_stall), 64'h0);
    send(1, 1, 64'he0, 1, 2, 64'he1);
    tick;
    send(1, 3, 64'he2, 0, 0, 0);
    tick;
    idle;
    chk("t6_valid", 64'(io.port_valid), 64'h0e);
    send(1, 1, 64'he3, 0, 0, 0);
    #1;
    rst = 1;
    #1;
    chk("t6_rst_valid", 64'(io.port_valid), 64'h0);
    chk("t6_rst_data", pd(1), 64'h0);
    chk("t6_rst_stall", 64'(io.send_stall), 64'h0);
    tick;
    rst = 0;
    idle;
    tick;
    chk("t6_after_rst", 64'(io.port_valid), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dyser_send_ingress.md
Name: dyser_send_ingress

Overview:
- Input-side stage of the DySER block, directly upstream of the fabric input switches.
- Accepts dual-lane dyser_send traffic from the core (lanes r0/r1), each lane carrying a port id and a data word.
- Steers each word into one of NPORTS per-port FIFOs and raises send_stall when a send cannot be fully accepted.
- Presents each FIFO head to the fabric through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 63, MSB index of the data word (word is DATA_WIDTH+1 = 64 bits).
- NPORTS, 8, number of DySER input ports; port id width is clog2(NPORTS) = 3.
- DEPTH, 4, entries per port FIFO; a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- send_data_r0  in  DATA_WIDTH+1  lane-0 data.
- send_data_r1  in  DATA_WIDTH+1  lane-1 data.
- send_port_r0  in  3  lane-0 target port.
- send_port_r1  in  3  lane-1 target port.
- send_en0  in  1  lane-0 send request.
- send_en1  in  1  lane-1 send request.
- config_en  in  1  configuration in progress; flushes all FIFOs.
- send_stall  out  1  combinational; the current send is not accepted.
- port_valid  out  NPORTS  per-port head-valid.
- port_data  out  NPORTS*(DATA_WIDTH+1)  per-port head data; port p occupies slice [p*64 +: 64].
- port_ready  in  NPORTS  fabric consumes the head of port p.

Behaviour:
- Reset (async, rst=1):
  - all FIFO counts, read pointers and write pointers go to 0.
  - port_valid = 0 and port_data = 0.
  - send_stall = 0 while rst is high.
- Reset asserted mid-operation discards all queued data immediately; sends presented during reset are dropped.
- Free space: free[p] = DEPTH - count[p], taken from registered count only. Same-cycle pops are not credited, which keeps the stall path short.
- need[p] = (send_en0 && port_r0==p) + (send_en1 && port_r1==p); the result is 0, 1 or 2.
- send_stall = |(need[p] > free[p]) over all p, OR config_en.
- Acceptance is atomic:
  - If send_stall=1, neither lane is written.
  - If send_stall=0, every enabled lane is written on the rising edge.
  - The core holds its inputs while stalled.
- When both lanes target the same port, lane 0 is written before lane 1, so FIFO order is r0 then r1.
- Pop: a pop occurs when port_valid[p] && port_ready[p]. port_ready while invalid is ignored.
- port_valid[p] = (count[p] != 0). port_data[p] is the FIFO head, driven from the storage array with no extra register. Latency from an accepted send edge to port_valid is 1 cycle.
- Count update per edge: count[p] <= count[p] + pushes[p] - pop[p].
  - Simultaneous push and pop is legal, including on a full FIFO when the push was admitted against the old count.
  - count never exceeds DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A double push advances wr_ptr by 2 with wrap.
- config_en=1 on a rising edge clears all counts and pointers (synchronous flush) and stalls all sends. This makes a new configuration start with empty queues.
- Port ids are always < NPORTS, so no out-of-range case exists with NPORTS=8.
- Send with send_en=0 on both lanes: no state change and send_stall=config_en.

Decomposition:
- Shared package dyser_pkg:
  - DATA_WIDTH and NPORTS.
  - PORT_W = 3.
  - the port-id typedef.
  - the data-word typedef, reused by the receive-side egress block.
- Sub-module dyser_port_fifo, instantiated NPORTS times:
  - inputs: push0, push1, din0, din1, pop, flush.
  - outputs: count, head, valid.
- Top level holds decode, need/free compare and stall logic.

Test Plan:
- Reset then dyser_send(4,0x0,3,0x1) -> send_stall=0; next cycle port_valid=8'b0001_1000, port_data[4]=0x0, port_data[3]=0x1.
- Both lanes to port 2 (0x55, 0xff), port_ready[2] held 0 -> head 0x55 then 0xff after one pop; count[2]=2.
- Fill port 6 to DEPTH=4 with port_ready=0, then send to port 6 -> send_stall=1, no write. With port_ready[6]=1 for one cycle -> the next cycle the send is accepted and order is preserved.
- Port 0 at count 3 and a dual send to port 0 -> send_stall=1 and the other lane is not written either (atomic). After one pop both are accepted.
- config_en=1 with data queued in ports 1 and 5 -> send_stall=1, and after the edge port_valid=0.
- Assert rst asynchronously mid-cycle with 3 ports non-empty -> port_valid=0 before the next clock edge and send_stall=0.
